// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and start-up FSM state type
// shared by the VGA sync generator and its interface.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: the generator drives it (master),
// the pixel/sprite stage consumes it (slave).
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic             hs;
   logic             vs;
   logic             blank;
   logic [CNT_W-1:0] DrawX;
   logic [CNT_W-1:0] DrawY;
   logic             line_start;
   logic             frame_start;

   modport master (
      output hs, vs, blank,
      output DrawX, DrawY,
      output line_start, frame_start
   );

   modport slave (
      input hs, vs, blank,
      input DrawX, DrawY,
      input line_start, frame_start
   );

endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA sync generator with registered outputs.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by one vga_clk.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int P_H_VISIBLE = H_VISIBLE,
   parameter int P_H_FRONT   = H_FRONT,
   parameter int P_H_SYNC    = H_SYNC,
   parameter int P_H_BACK    = H_BACK,
   parameter int P_V_VISIBLE = V_VISIBLE,
   parameter int P_V_FRONT   = V_FRONT,
   parameter int P_V_SYNC    = V_SYNC,
   parameter int P_V_BACK    = V_BACK
) (
   input  logic            vga_clk,
   input  logic            reset_n,
   vga_sync_gen_if.master  vif
);

   localparam int LP_H_TOT = P_H_VISIBLE + P_H_FRONT
                           + P_H_SYNC + P_H_BACK;
   localparam int LP_V_TOT = P_V_VISIBLE + P_V_FRONT
                           + P_V_SYNC + P_V_BACK;

   localparam logic [CNT_W-1:0] LP_H_LAST =
      CNT_W'(LP_H_TOT - 1);
   localparam logic [CNT_W-1:0] LP_V_LAST =
      CNT_W'(LP_V_TOT - 1);
   localparam logic [CNT_W-1:0] LP_H_VIS =
      CNT_W'(P_H_VISIBLE);
   localparam logic [CNT_W-1:0] LP_V_VIS =
      CNT_W'(P_V_VISIBLE);
   localparam logic [CNT_W-1:0] LP_HS_BEG =
      CNT_W'(P_H_VISIBLE + P_H_FRONT);
   localparam logic [CNT_W-1:0] LP_HS_END =
      CNT_W'(P_H_VISIBLE + P_H_FRONT + P_H_SYNC - 1);
   localparam logic [CNT_W-1:0] LP_VS_BEG =
      CNT_W'(P_V_VISIBLE + P_V_FRONT);
   localparam logic [CNT_W-1:0] LP_VS_END =
      CNT_W'(P_V_VISIBLE + P_V_FRONT + P_V_SYNC - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_hc;
   logic [CNT_W-1:0] r_vc;
   logic [CNT_W-1:0] w_hc_nxt;
   logic [CNT_W-1:0] w_vc_nxt;
   logic             r_hs;
   logic             r_vs;
   logic             r_blank;
   logic             r_ls;
   logic             r_fs;
   logic             w_hs_nxt;
   logic             w_vs_nxt;
   logic             w_blank_nxt;
   logic             w_ls_nxt;
   logic             w_fs_nxt;

   // IDLE holds the counters at (0,0) for one edge so frame 0
   // begins with a full pixel (0,0) rather than (1,0).
   always_comb begin
      w_state_nxt = RUN;
      w_hc_nxt    = r_hc;
      w_vc_nxt    = r_vc;
      unique case (r_state)
         IDLE: begin
            w_hc_nxt = '0;
            w_vc_nxt = '0;
         end
         RUN: begin
            if (r_hc == LP_H_LAST) begin
               w_hc_nxt = '0;
               if (r_vc == LP_V_LAST)
                  w_vc_nxt = '0;
               else
                  w_vc_nxt = r_vc + 1'b1;
            end else begin
               w_hc_nxt = r_hc + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      w_hs_nxt    = 1'b1;
      w_vs_nxt    = 1'b1;
      w_blank_nxt = 1'b0;
      w_ls_nxt    = 1'b0;
      w_fs_nxt    = 1'b0;
      if (w_hc_nxt >= LP_HS_BEG && w_hc_nxt <= LP_HS_END)
         w_hs_nxt = 1'b0;
      if (w_vc_nxt >= LP_VS_BEG && w_vc_nxt <= LP_VS_END)
         w_vs_nxt = 1'b0;
      if (w_hc_nxt < LP_H_VIS && w_vc_nxt < LP_V_VIS)
         w_blank_nxt = 1'b1;
      if (w_hc_nxt == '0)
         w_ls_nxt = 1'b1;
      if (w_hc_nxt == '0 && w_vc_nxt == '0)
         w_fs_nxt = 1'b1;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_hc    <= '0;
         r_vc    <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_blank <= 1'b0;
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hc    <= w_hc_nxt;
         r_vc    <= w_vc_nxt;
         r_hs    <= w_hs_nxt;
         r_vs    <= w_vs_nxt;
         r_blank <= w_blank_nxt;
         r_ls    <= w_ls_nxt;
         r_fs    <= w_fs_nxt;
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   // Extra stage matches the sprite ROM/palette latency downstream.
   logic r_hs_d;
   logic r_vs_d;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hs_d <= 1'b1;
         r_vs_d <= 1'b1;
      end else begin
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
      end
   end

   assign vif.hs = r_hs_d;
   assign vif.vs = r_vs_d;
`else
   assign vif.hs = r_hs;
   assign vif.vs = r_vs;
`endif

   assign vif.blank       = r_blank;
   assign vif.DrawX       = r_hc;
   assign vif.DrawY       = r_vc;
   assign vif.line_start  = r_ls;
   assign vif.frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen with a shortened vertical
// timing (13 lines) so whole frames fit in a short run.
module tb_vga_sync_gen;

   localparam int FRAME = 800 * 13;

`ifdef VGA_SYNC_ALIGN_EN
   localparam bit A = 1'b1;
`else
   localparam bit A = 1'b0;
`endif

   typedef struct {
      int          n;
      logic [24:0] v;
      string       nm;
   } exp_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 vga_clk = ~vga_clk;

   vga_sync_gen_if vif ();

   vga_sync_gen #(
      .P_V_VISIBLE (6),
      .P_V_FRONT   (2),
      .P_V_SYNC    (2),
      .P_V_BACK    (3)
   ) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vif     (vif)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n = 0;
   int   run = 0;
   int   hs_lo = 0;
   int   vs_lo = 0;
   int   bl_hi = 0;
   int   ls_cnt = 0;
   int   last_fs = 0;
   int   fs_period = 0;

   wire [24:0] w_got = {vif.DrawX, vif.DrawY, vif.hs, vif.vs,
                        vif.blank, vif.line_start,
                        vif.frame_start};

   function automatic logic [24:0] pk(
      int x, int y, logic hs, logic vs,
      logic bl, logic ls, logic fs);
      return {10'(x), 10'(y), hs, vs, bl, ls, fs};
   endfunction

   task automatic cmp(string nm, logic [24:0] got,
                      logic [24:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                  nm, got[24:15], got[14:5], got[4], got[3],
                  got[2], got[1], got[0], want[24:15],
                  want[14:5], want[4], want[3], want[2],
                  want[1], want[0]);
      end
   endtask

   task automatic cmp_int(string nm, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic push(int cyc, string nm, logic [24:0] v);
      exp_t e;
      e.n  = cyc;
      e.v  = v;
      e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: n counts posedges since release, sampled at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge vga_clk);
         if (!reset_n) begin
            n = 0;
            cmp("in_reset", w_got, pk(0, 0, 1, 1, 0, 0, 0));
         end else begin
            n++;
            if (run == 1 && n <= FRAME) begin
               if (!vif.hs) hs_lo++;
               if (!vif.vs) vs_lo++;
               if (vif.blank) bl_hi++;
               if (vif.line_start) ls_cnt++;
            end
            if (run == 1 && vif.frame_start) begin
               if (last_fs > 0 && fs_period == 0)
                  fs_period = n - last_fs;
               last_fs = n;
            end
            if (q.size() > 0 && q[0].n == n) begin
               e = q.pop_front();
               cmp(e.nm, w_got, e.v);
            end
         end
      end
   end

   initial begin
      push(1,     "origin",     pk(0,   0,  1,  1, 1, 1, 1));
      push(2,     "x1",         pk(1,   0,  1,  1, 1, 0, 0));
      push(640,   "last_vis",   pk(639, 0,  1,  1, 1, 0, 0));
      push(641,   "blank_fall", pk(640, 0,  1,  1, 0, 0, 0));
      push(657,   "hs_x656",    pk(656, 0,  A,  1, 0, 0, 0));
      push(658,   "hs_x657",    pk(657, 0,  0,  1, 0, 0, 0));
      push(752,   "hs_x751",    pk(751, 0,  0,  1, 0, 0, 0));
      push(753,   "hs_x752",    pk(752, 0,  ~A, 1, 0, 0, 0));
      push(800,   "eol",        pk(799, 0,  1,  1, 0, 0, 0));
      push(801,   "line1",      pk(0,   1,  1,  1, 1, 1, 0));
      push(4640,  "y5_vis",     pk(639, 5,  1,  1, 1, 0, 0));
      push(4641,  "y5_blank",   pk(640, 5,  1,  1, 0, 0, 0));
      push(4801,  "y6_blank",   pk(0,   6,  1,  1, 0, 1, 0));
      push(6401,  "vs_y8x0",    pk(0,   8,  1,  A, 0, 1, 0));
      push(6402,  "vs_y8x1",    pk(1,   8,  1,  0, 0, 0, 0));
      push(8000,  "vs_y9end",   pk(799, 9,  1,  0, 0, 0, 0));
      push(8001,  "vs_y10",     pk(0,   10, 1,  ~A, 0, 1, 0));
      push(10400, "pre_wrap",   pk(799, 12, 1,  1, 0, 0, 0));
      push(10401, "wrap",       pk(0,   0,  1,  1, 1, 1, 1));

      run = 1;
      reset_n = 1'b0;
      repeat (10) @(posedge vga_clk);
      #7 reset_n = 1'b1;

      // (300,2) of frame 1: pixel index 10400 + 1600 + 300
      repeat (12301) @(posedge vga_clk);
      #2;
      cmp("pre_reset", w_got, pk(300, 2, 1, 1, 1, 0, 0));
      reset_n = 1'b0;
      #1;
      cmp("async_reset", w_got, pk(0, 0, 1, 1, 0, 0, 0));

      push(1,   "restart",    pk(0, 0, 1, 1, 1, 1, 1));
      push(2,   "restart_x1", pk(1, 0, 1, 1, 1, 0, 0));
      push(801, "restart_y1", pk(0, 1, 1, 1, 1, 1, 0));
      run = 2;
      repeat (3) @(posedge vga_clk);
      #7 reset_n = 1'b1;
      repeat (900) @(posedge vga_clk);
      @(negedge vga_clk);
      #1;

      cmp_int("hs_low_cycles", hs_lo, 96 * 13);
      cmp_int("vs_low_cycles", vs_lo, 1600);
      cmp_int("blank_high_cycles", bl_hi, 640 * 6);
      cmp_int("line_start_count", ls_cnt, 13);
      cmp_int("frame_period", fs_period, FRAME);
      cmp_int("queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001: H_VISIBLE, 640: visible pixels per line.
- REQ-002: H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths in pixels; line total = 800.
- REQ-003: V_VISIBLE, 480: visible lines per frame.
- REQ-004: V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths in lines; frame total = 525.
- REQ-005: vga_clk  in  1  pixel clock; sole clock; all flops on posedge.
- REQ-006: reset_n  in  1  asynchronous, active-low reset.
- REQ-007: hs  out  1  horizontal sync, active-low.
- REQ-008: vs  out  1  vertical sync, active-low.
- REQ-009: blank  out  1  display enable; 1 = pixel visible. Downstream drives colour only when high.
- REQ-010: DrawX  out  10  current pixel column, 0..799.
- REQ-011: DrawY  out  10  current line, 0..524.
- REQ-012: line_start  out  1  one-cycle pulse coincident with DrawX == 0.
- REQ-013: frame_start  out  1  one-cycle pulse coincident with DrawX == 0 and DrawY == 0.

Function
- REQ-014: hc (10 b) increments every cycle; wraps 799 -> 0. On wrap, vc (10 b) increments; vc wraps 524 -> 0 when hc wraps.
- REQ-015: All outputs are flop outputs. hs, vs, blank, line_start and frame_start are decoded from the next-state counter values so that they align with DrawX/DrawY in the same cycle; no combinational path from counters to ports.
- REQ-016: hs = 0 iff 656 <= DrawX <= 751; vs = 0 iff 490 <= DrawY <= 491.
- REQ-017: blank = 1 iff DrawX < 640 and DrawY < 480.
- REQ-018: Start-up FSM with states IDLE and RUN. IDLE is entered on reset. The first posedge after reset_n rises moves to RUN without advancing the counters, so pixel (0,0) of frame 0 is presented with blank = 1 and frame_start = 1. RUN is held until reset.
- REQ-019: Boundary (799,524) -> (0,0): DrawX, DrawY, line_start and frame_start all update in the same cycle; vs deasserted.
- REQ-020: Boundary (639,y) -> (640,y): blank falls on the cycle DrawX = 640.
- REQ-021: No handshake or back-pressure; timing is free-running.

Reset
- REQ-022: While reset_n = 0: DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0, FSM = IDLE.
- REQ-023: Asserting reset mid-frame forces these values asynchronously. After release, the first frame restarts at (0,0) per REQ-018.

Configuration
- REQ-024: Macro VGA_SYNC_ALIGN_EN, when defined, delays hs and vs by one extra vga_clk cycle. This matches the one-cycle ROM/palette/output-register latency of the downstream sprite stage. DrawX, DrawY, blank and the pulses are not delayed.
- REQ-025: Without VGA_SYNC_ALIGN_EN, hs and vs align exactly with DrawX/DrawY per REQ-016. The delay flops reset to 1.

Structure
- REQ-026: Package vga_timing_pkg holds the default timing constants: H/V visible, front, sync, back, totals, and the derived sync start/end positions. The same package also holds the FSM state typedef (IDLE, RUN).
- REQ-027: Single module with no sub-modules; the counters and decode are too small to split.

Verification
- REQ-028: Reset held 10 cycles then released. Required: outputs at reset values during reset; first edge after release gives DrawX = 0, DrawY = 0, blank = 1, frame_start = 1.
- REQ-029: Run 800 cycles from (0,0). Required: hs low for exactly 96 cycles starting at DrawX = 656; line_start pulses at cycle 800 with DrawY = 1.
- REQ-030: Run one full frame (420000 cycles). Required: vs low for exactly 1600 cycles starting at DrawY = 490; frame_start period = 420000; blank high for 307200 cycles.
- REQ-031: Assert reset_n low at DrawX = 300, DrawY = 200. Required: outputs forced to reset values immediately, not at the next edge; restart at (0,0).
- REQ-032: With VGA_SYNC_ALIGN_EN defined: hs falls at DrawX = 657 and vs falls at DrawX = 1, DrawY = 490. blank is unchanged, still falling at DrawX = 640.
- REQ-033: Wrap check at (799,524). Next cycle: DrawX = 0, DrawY = 0, frame_start = 1, line_start = 1, hs = 1, vs = 1.
